// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package hazard_pkg;

  localparam int REG_W = 4;
  localparam logic [REG_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  // Register 0 is hard-wired, so it never creates a dependency.
  function automatic logic reg_match(input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] dst);
    return (src == dst) && (dst != ZERO_REG);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational detection of the hazards forwarding cannot cover:
// load-use in ID and a JR whose target register is still being loaded.
module hazard_detect
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_jr,
  input  logic [REG_W-1:0] id_ex_rd,
  input  logic             id_ex_rw,
  input  logic             id_ex_memrd,
  input  logic [REG_W-1:0] ex_mem_rd,
  input  logic             ex_mem_rw,
  input  logic             ex_mem_memrd,
  output logic             load_use,
  output logic             jr_haz
);

  logic ex_load;
  logic mem_load;

  assign ex_load  = id_ex_memrd & id_ex_rw;
  assign mem_load = ex_mem_memrd & ex_mem_rw;

  assign load_use = ex_load &
                    ((id_uses_rs & reg_match(id_rs, id_ex_rd)) |
                     (id_uses_rt & reg_match(id_rt, id_ex_rd)));

  // JR reads rs in ID, so a load still in EX or MEM cannot be forwarded in time.
  assign jr_haz = id_is_jr &
                  ((ex_load  & reg_match(id_rs, id_ex_rd)) |
                   (mem_load & reg_match(id_rs, ex_mem_rd)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: FSM for memory waits and halt, stall
// counter, and the priority mux producing stage enables and bubble controls.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_jr,
  input  logic             id_is_hlt,
  input  logic [REG_W-1:0] id_ex_rd,
  input  logic             id_ex_rw,
  input  logic             id_ex_memrd,
  input  logic [REG_W-1:0] ex_mem_rd,
  input  logic             ex_mem_rw,
  input  logic             ex_mem_memrd,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

  state_t          state, nxt;
  logic [WC_W-1:0] wait_cnt;
  logic            load_use, jr_haz, stall, freeze;

  hazard_detect u_detect (
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_is_jr     (id_is_jr),
    .id_ex_rd     (id_ex_rd),
    .id_ex_rw     (id_ex_rw),
    .id_ex_memrd  (id_ex_memrd),
    .ex_mem_rd    (ex_mem_rd),
    .ex_mem_rw    (ex_mem_rw),
    .ex_mem_memrd (ex_mem_memrd),
    .load_use     (load_use),
    .jr_haz       (jr_haz)
  );

  assign stall = load_use | jr_haz;
  // The release cycle of a wait is not a freeze: the pipeline moves on mem_ready.
  assign freeze = ((state == MEM_WAIT) | ((state == RUN) & mem_req)) & ~mem_ready;

  always_comb begin
    nxt = state;
    case (state)
      RUN: begin
        if (mem_req & ~mem_ready)                   nxt = MEM_WAIT;
        else if (id_is_hlt & ~branch_taken & ~stall) nxt = HALT;
      end
      MEM_WAIT: begin
        if (mem_ready)              nxt = RUN;
        else if (wait_cnt == WC_LAST) nxt = HALT;
      end
      HALT:    nxt = HALT;
      default: nxt = RUN;
    endcase
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    halted       = 1'b0;
    if (!rst_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (state == HALT) begin
      // Keep injecting bubbles so older instructions drain past EX.
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
      halted      = 1'b1;
    end else if (freeze) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= RUN;
      wait_cnt     <= '0;
      mem_err      <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state <= nxt;
      if (state == RUN && nxt == MEM_WAIT)
        wait_cnt <= '0;
      else if (state == MEM_WAIT && !mem_ready)
        wait_cnt <= wait_cnt + 1'b1;
      if (state == MEM_WAIT && nxt == HALT)
        mem_err <= 1'b1;
      if (!pc_write && state != HALT && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table plus multi-cycle sequences.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] id_rs, id_rt, id_ex_rd, ex_mem_rd;
  logic id_uses_rs, id_uses_rt, id_is_jr, id_is_hlt;
  logic id_ex_rw, id_ex_memrd, ex_mem_rw, ex_mem_memrd;
  logic branch_taken, mem_req, mem_ready;
  logic pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic if_id_flush, id_ex_flush, halted, mem_err;
  logic [CNT_W-1:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_jr(id_is_jr), .id_is_hlt(id_is_hlt),
    .id_ex_rd(id_ex_rd), .id_ex_rw(id_ex_rw), .id_ex_memrd(id_ex_memrd),
    .ex_mem_rd(ex_mem_rd), .ex_mem_rw(ex_mem_rw), .ex_mem_memrd(ex_mem_memrd),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .ex_mem_write(ex_mem_write), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .halted(halted), .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  // Output order: {pc, if_id, id_ex, ex_mem, if_id_flush, id_ex_flush, halted, mem_err}
  localparam logic [7:0] O_NORM  = 8'b1111_0000;
  localparam logic [7:0] O_STALL = 8'b0011_0100;
  localparam logic [7:0] O_BR    = 8'b1111_1100;
  localparam logic [7:0] O_FRZ   = 8'b0000_0000;
  localparam logic [7:0] O_HALT  = 8'b0011_0110;
  localparam logic [7:0] O_MERR  = 8'b0011_0111;
  localparam logic [7:0] O_RST   = 8'b0000_1100;

  typedef struct {
    string      name;
    logic [3:0] rs, rt;
    logic       urs, urt, jr, hlt;
    logic [3:0] xrd;
    logic       xrw, xmr;
    logic [3:0] mrd;
    logic       mrw, mmr;
    logic       br, req, rdy;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } sb_t;

  sb_t sb[$];

  function automatic vec_t mk(string n, logic [3:0] rs, logic [3:0] rt, logic urs, logic urt,
                              logic jr, logic hlt, logic [3:0] xrd, logic xrw, logic xmr,
                              logic [3:0] mrd, logic mrw, logic mmr,
                              logic br, logic req, logic rdy, logic [7:0] exp);
    vec_t v;
    v.name = n; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.jr = jr; v.hlt = hlt;
    v.xrd = xrd; v.xrw = xrw; v.xmr = xmr; v.mrd = mrd; v.mrw = mrw; v.mmr = mmr;
    v.br = br; v.req = req; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.urs; id_uses_rt = v.urt;
    id_is_jr = v.jr; id_is_hlt = v.hlt;
    id_ex_rd = v.xrd; id_ex_rw = v.xrw; id_ex_memrd = v.xmr;
    ex_mem_rd = v.mrd; ex_mem_rw = v.mrw; ex_mem_memrd = v.mmr;
    branch_taken = v.br; mem_req = v.req; mem_ready = v.rdy;
    sb.push_back('{v.name, v.exp});
  endtask

  task automatic check_outs();
    sb_t e;
    logic [7:0] act;
    act = {pc_write, if_id_write, id_ex_write, ex_mem_write,
           if_id_flush, id_ex_flush, halted, mem_err};
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty got=%b", act);
    end else begin
      e = sb.pop_front();
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s got=%b want=%b", e.name, act, e.exp);
      end
    end
  endtask

  // Drive one cycle, compare at the falling edge, then cross the rising edge.
  task automatic step(input vec_t v);
    drive(v);
    @(negedge clk);
    check_outs();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string n, input int want);
    total++;
    if (stall_cycles !== CNT_W'(want)) begin
      bad++;
      $display("FAIL %s stall_cycles got=%0d want=%0d", n, stall_cycles, want);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(mk("reset_outputs", 0,0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, O_RST));
    @(posedge clk);
    #1;
    @(negedge clk);
    check_outs();
    check_cnt("reset_cnt", 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  vec_t idle;
  vec_t tbl[$];

  initial begin
    idle = mk("idle", 0,0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, O_NORM);

    tbl.push_back(idle);
    tbl.push_back(mk("lu_rs",        3,0,1,0,0,0, 3,1,1, 0,0,0, 0,0,0, O_STALL));
    tbl.push_back(mk("lu_rt",        0,3,0,1,0,0, 3,1,1, 0,0,0, 0,0,0, O_STALL));
    tbl.push_back(mk("lu_unused_rs", 3,0,0,0,0,0, 3,1,1, 0,0,0, 0,0,1, O_NORM));
    tbl.push_back(mk("lu_r0",        0,0,1,1,0,0, 0,1,1, 0,0,0, 0,0,0, O_NORM));
    tbl.push_back(mk("alu_fwd",      3,3,1,1,0,0, 3,1,0, 0,0,0, 0,0,0, O_NORM));
    tbl.push_back(mk("jr_ex_load",   5,0,0,0,1,0, 5,1,1, 0,0,0, 0,0,0, O_STALL));
    tbl.push_back(mk("jr_ex_alu",    5,0,0,0,1,0, 5,1,0, 0,0,0, 0,0,0, O_NORM));
    tbl.push_back(mk("jr_mem_load",  5,0,0,0,1,0, 0,0,0, 5,1,1, 0,0,0, O_STALL));
    tbl.push_back(mk("jr_mem_alu",   5,0,0,0,1,0, 0,0,0, 5,1,0, 0,0,0, O_NORM));
    tbl.push_back(mk("jr_r0",        0,0,0,0,1,0, 0,1,1, 0,1,1, 0,0,0, O_NORM));
    tbl.push_back(mk("jr_mem_norw",  5,0,0,0,1,0, 0,0,0, 5,0,1, 0,0,0, O_NORM));
    tbl.push_back(mk("br_beats_lu",  3,0,1,0,0,0, 3,1,1, 0,0,0, 1,0,0, O_BR));
    tbl.push_back(mk("mem_hit",      0,0,0,0,0,0, 0,0,0, 0,0,0, 0,1,1, O_NORM));

    do_reset();
    foreach (tbl[i]) step(tbl[i]);
    check_cnt("table_stalls", 4);

    // Load-use: one bubble, then the load has moved on to EX/MEM.
    do_reset();
    step(mk("lu_seq0", 3,0,1,0,0,0, 3,1,1, 0,0,0, 0,0,0, O_STALL));
    step(mk("lu_seq1", 3,0,1,0,0,0, 0,0,0, 3,1,1, 0,0,0, O_NORM));
    check_cnt("lu_seq_cnt", 1);

    // JR behind a load in EX: two bubbles.
    do_reset();
    step(mk("jr_seq0", 5,0,1,0,1,0, 5,1,1, 0,0,0, 0,0,0, O_STALL));
    step(mk("jr_seq1", 5,0,1,0,1,0, 0,0,0, 5,1,1, 0,0,0, O_STALL));
    step(mk("jr_seq2", 5,0,1,0,1,0, 0,0,0, 0,0,0, 0,0,0, O_NORM));
    check_cnt("jr_seq_cnt", 2);

    do_reset();
    step(mk("jr_nold0", 5,0,1,0,1,0, 5,1,0, 0,0,0, 0,0,0, O_NORM));
    step(mk("jr_nold1", 5,0,1,0,1,0, 0,0,0, 5,1,0, 0,0,0, O_NORM));
    step(mk("jr_rd0",   0,0,1,0,1,0, 0,1,1, 0,0,0, 0,0,0, O_NORM));
    check_cnt("jr_nostall_cnt", 0);

    // Memory wait of 3 cycles; a branch arriving mid-freeze flushes on release.
    do_reset();
    step(mk("mw0", 0,0,0,0,0,0, 0,0,0, 0,0,0, 0,1,0, O_FRZ));
    step(mk("mw1", 0,0,0,0,0,0, 0,0,0, 0,0,0, 1,1,0, O_FRZ));
    step(mk("mw2", 0,0,0,0,0,0, 0,0,0, 0,0,0, 1,1,0, O_FRZ));
    step(mk("mw_release", 0,0,0,0,0,0, 0,0,0, 0,0,0, 1,1,1, O_BR));
    step(idle);
    check_cnt("mw_cnt", 3);

    // Timeout: entry cycle plus four MEM_WAIT cycles, then sticky error/halt.
    do_reset();
    for (int i = 0; i < 5; i++)
      step(mk($sformatf("to_frz%0d", i), 0,0,0,0,0,0, 0,0,0, 0,0,0, 0,1,0, O_FRZ));
    step(mk("to_err0", 0,0,0,0,0,0, 0,0,0, 0,0,0, 0,1,0, O_MERR));
    step(mk("to_err1", 0,0,0,0,0,0, 0,0,0, 0,0,0, 0,1,1, O_MERR));
    step(mk("to_err2", 3,0,1,0,0,0, 3,1,1, 0,0,0, 0,0,0, O_MERR));
    check_cnt("to_cnt", 5);
    do_reset();
    step(idle);
    check_cnt("to_post_reset_cnt", 0);

    // HLT with no hazard halts next cycle; counter stays frozen.
    do_reset();
    step(mk("hlt0", 0,0,0,0,0,1, 0,0,0, 0,0,0, 0,0,0, O_NORM));
    for (int i = 0; i < 3; i++)
      step(mk($sformatf("hlt_hold%0d", i), 0,0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, O_HALT));
    check_cnt("hlt_cnt", 0);

    // HLT blocked by a load-use stall does not halt.
    do_reset();
    step(mk("hlt_lu0", 3,0,1,0,0,1, 3,1,1, 0,0,0, 0,0,0, O_STALL));
    step(mk("hlt_lu1", 0,0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, O_NORM));
    check_cnt("hlt_lu_cnt", 1);

    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline stall/flush controller for the 5-stage core. It is the producer of the pipeline-register write enables and flush controls that the forwarding logic relies on. It detects hazards that forwarding cannot cover: load-use, JR-after-load, taken branches, multi-cycle data-memory waits and HLT. From these it generates per-stage hold and bubble controls. It sits beside the forwarding unit and is driven by ID, ID/EX and EX/MEM fields plus the data-memory handshake.

## Interface

Parameters:
- `MEM_TIMEOUT`, default 64: maximum consecutive MEM_WAIT cycles before `mem_err`.
- `CNT_W`, default 16: width of the stall-cycle counter.

Ports:
- `clk` in 1: core clock.
- `rst_n` in 1: synchronous, active-low reset.
- `id_rs`, `id_rt` in 4: source registers of the instruction in ID.
- `id_uses_rs`, `id_uses_rt` in 1: ID instruction actually reads rs / rt.
- `id_is_jr` in 1: ID instruction is JR (rs is consumed in ID).
- `id_is_hlt` in 1: ID instruction is HLT.
- `id_ex_rd` in 4; `id_ex_rw`, `id_ex_memrd` in 1: destination, regwrite and load flag in ID/EX.
- `ex_mem_rd` in 4; `ex_mem_rw`, `ex_mem_memrd` in 1: same fields in EX/MEM.
- `branch_taken` in 1: EX resolved a taken branch or jump.
- `mem_req` in 1: EX/MEM holds a load or store.
- `mem_ready` in 1: data memory completes the access this cycle.
- `pc_write`, `if_id_write`, `id_ex_write`, `ex_mem_write` out 1: stage enables (1 = advance).
- `if_id_flush`, `id_ex_flush` out 1: load a bubble into the register.
- `halted` out 1: core halted.
- `mem_err` out 1: memory timeout, sticky.
- `stall_cycles` out CNT_W: saturating count of cycles with `pc_write` = 0 while not halted.

## Operation

Register 0 is never a hazard source. Any compare with rd = 0 is false.

Hazard terms:
- `load_use` = `id_ex_memrd` & `id_ex_rw` & (`id_ex_rd` ≠ 0) & ((`id_uses_rs` & `id_rs` == `id_ex_rd`) | (`id_uses_rt` & `id_rt` == `id_ex_rd`)).
- `jr_haz` = `id_is_jr` & (`id_rs` ≠ 0) & ((`id_ex_rw` & `id_rs` == `id_ex_rd` & `id_ex_memrd`) | (`ex_mem_rw` & `ex_mem_memrd` & `id_rs` == `ex_mem_rd`)).
  - A JR depending on a non-load in EX is forwarded and does not stall.

FSM states:
- RUN
- MEM_WAIT
- HALT

Transitions:
- RUN → MEM_WAIT: `mem_req` & !`mem_ready`.
- RUN → HALT: `id_is_hlt` & no freeze, flush or stall this cycle.
- MEM_WAIT → RUN: `mem_ready`. The pipeline advances in that same cycle.
- MEM_WAIT → HALT: wait counter reaches `MEM_TIMEOUT`. `mem_err` is set.
- HALT is left only by reset.

Outputs are combinational from state and inputs, in priority order:
1. HALT: `pc_write` = `if_id_write` = 0, `id_ex_flush` = 1. EX/MEM and later stages keep running so older instructions drain. `halted` = 1.
2. Freeze (MEM_WAIT, or RUN with `mem_req` & !`mem_ready`): all four enables = 0, no flushes.
3. `branch_taken`: all enables = 1, `if_id_flush` = `id_ex_flush` = 1.
4. `load_use` | `jr_haz`: `pc_write` = `if_id_write` = 0, `id_ex_flush` = 1, other enables = 1.
5. Otherwise: all enables = 1, no flushes.

Other rules:
- A branch that arrives during a freeze is held in EX, so `branch_taken` stays high. The flush applies on the release cycle.
- `stall_cycles` increments each cycle in which `pc_write` = 0 and the state is not HALT. It saturates at all-ones.

## Timing

Reset (`rst_n` low at a rising edge):
- State → RUN; `stall_cycles`, wait counter and `mem_err` → 0.
- While `rst_n` is low, outputs are forced: all enables = 0, both flushes = 1, `halted` = 0.

Latency:
- Stall and flush decisions take effect at the next edge (zero-cycle combinational).
- Load-use costs 1 bubble.
- JR costs 2 bubbles behind a load in EX, and 1 bubble behind a load in MEM.
- Wait counter: cleared on entry to MEM_WAIT, incremented per MEM_WAIT cycle. `mem_err` asserts on the edge where it equals `MEM_TIMEOUT`.
- `mem_ready` high with `mem_req` high in RUN: no wait state and no counter change.

## Structure

- `hazard_pkg`: state enum (RUN, MEM_WAIT, HALT), register-address width 4, ZERO_REG constant.
- Sub-module `hazard_detect`: purely combinational; produces `load_use` and `jr_haz`.
- `hazard_ctrl`: contains the FSM, counters and output priority mux.

## Test plan

- Load r3 in ID/EX, ID reads rs = r3 → one cycle with `pc_write` = 0 and `id_ex_flush` = 1, then normal; `stall_cycles` = 1.
- JR r5 in ID, load r5 in ID/EX → 2 stall cycles. The same case with `id_ex_memrd` = 0 → 0 stalls. The same case with rd = 0 → 0 stalls.
- `mem_req` = 1 with `mem_ready` low for 3 cycles → all enables 0 for 3 cycles; resume on the `mem_ready` cycle; `stall_cycles` = 3.
- `branch_taken` together with `load_use` → flush wins: enables 1, both flushes 1, no stall.
- `mem_ready` held low for `MEM_TIMEOUT` = 4 cycles → `mem_err` = 1 and `halted` = 1. Both stay set until `rst_n` low; after reset all counters are 0.
- HLT in ID with no hazard → HALT next cycle; `pc_write` stays 0 and `stall_cycles` stops counting.
